// File: rtl/lcd_cmd_sequencer_pkg.sv
// Shared definitions for the LCD command sequencer.
// Holds the 4-bit LCD opcode constants, the issue FSM state encoding, and
// a helper that tells legal opcodes from undefined ones.
package lcd_pkg;

    typedef logic [3:0] cmd_t;

    localparam cmd_t CMD_WRITE       = 4'd0;
    localparam cmd_t CMD_SHIFT_UP    = 4'd1;
    localparam cmd_t CMD_SHIFT_DOWN  = 4'd2;
    localparam cmd_t CMD_SHIFT_LEFT  = 4'd3;
    localparam cmd_t CMD_SHIFT_RIGHT = 4'd4;
    localparam cmd_t CMD_MAX         = 4'd5;
    localparam cmd_t CMD_MIN         = 4'd6;
    localparam cmd_t CMD_AVERAGE     = 4'd7;
    localparam cmd_t CMD_ROT_CCW     = 4'd8;
    localparam cmd_t CMD_ROT_CW      = 4'd9;
    localparam cmd_t CMD_MIRROR_X    = 4'd10;
    localparam cmd_t CMD_MIRROR_Y    = 4'd11;
    localparam cmd_t CMD_LAST        = CMD_MIRROR_Y;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_WDONE = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    function automatic logic cmd_is_legal(input cmd_t c);
        return (c <= CMD_LAST);
    endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// Handshake bundle for the LCD command sequencer.
// Carries both requester valid/cmd/ready channels and the LCD controller
// cmd/cmd_valid/busy/done port.
//   master : requester + LCD controller side (drives requests, busy, done)
//   slave  : sequencer side (drives ready, lcd_cmd, lcd_cmd_valid)
interface lcd_cmd_sequencer_if;
    import lcd_pkg::*;

    logic req0_valid;
    cmd_t req0_cmd;
    logic req0_ready;
    logic req1_valid;
    cmd_t req1_cmd;
    logic req1_ready;
    cmd_t lcd_cmd;
    logic lcd_cmd_valid;
    logic lcd_busy;
    logic lcd_done;

    modport master (
        output req0_valid, req0_cmd, req1_valid, req1_cmd, lcd_busy, lcd_done,
        input  req0_ready, req1_ready, lcd_cmd, lcd_cmd_valid
    );

    modport slave (
        input  req0_valid, req0_cmd, req1_valid, req1_cmd, lcd_busy, lcd_done,
        output req0_ready, req1_ready, lcd_cmd, lcd_cmd_valid
    );

endinterface

// File: rtl/lcd_cmd_sequencer_fifo.sv
// Synchronous command FIFO used by the LCD command sequencer.
// Ports: clk, reset (async, active-high), push/din, pop/dout (head, valid
// whenever not empty), full, empty, level (occupancy 0..DEPTH).
// DEPTH must be a power of two so the pointers wrap naturally.
module lcd_cmd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// LCD command sequencer: round-robin arbiter for two requesters feeding a
// command FIFO, plus an issue FSM that hands commands one at a time to the
// LCD controller and supervises each with a watchdog.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   bus (slave)  : requester valid/cmd/ready pairs and LCD cmd/valid/busy/done
//   clr_err      : clears the sticky error flags
//   fifo_level   : FIFO occupancy
//   idle         : FIFO empty, FSM idle and LCD not busy
//   write_cnt    : completed Write commands (wraps)
//   err_timeout  : sticky, watchdog expired
//   err_illegal  : sticky, opcode 12..15 was granted
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter  int DEPTH   = 4,
    parameter  int TIMEOUT = 255,
    parameter  int CNT_W   = 8,
    localparam int LW      = $clog2(DEPTH + 1),
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    lcd_cmd_sequencer_if.slave   bus,
    input  logic                 clr_err,
    output logic [LW-1:0]        fifo_level,
    output logic                 idle,
    output logic [CNT_W-1:0]     write_cnt,
    output logic                 err_timeout,
    output logic                 err_illegal
);

    logic   fifo_full;
    logic   fifo_empty;
    cmd_t   fifo_head;
    logic   push;
    logic   pop;
    cmd_t   sel_cmd;
    logic   grant0;
    logic   grant1;
    logic   contested;
    logic   new_illegal;
    logic   rr_ptr;          // 0 favours req0, 1 favours req1

    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n;
    cmd_t             cmd_q, cmd_n;
    logic             valid_q, valid_n;
    logic             is_write, is_write_n;
    logic [CNT_W-1:0] wcnt_n;
    logic             timeout_hit;

    lcd_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(4)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (sel_cmd),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Arbiter: ready is decided from the pre-pop FIFO state, so a full FIFO
    // refuses both requesters even when a pop happens in the same cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!fifo_full) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = !rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign contested      = bus.req0_valid && bus.req1_valid && !fifo_full;
    assign sel_cmd        = grant1 ? bus.req1_cmd : bus.req0_cmd;
    // Illegal opcodes are acknowledged but never enter the FIFO.
    assign push           = (grant0 || grant1) && cmd_is_legal(sel_cmd);
    assign new_illegal    = (grant0 || grant1) && !cmd_is_legal(sel_cmd);
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // The pointer only moves when it actually settled a contest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (contested) begin
            rr_ptr <= !rr_ptr;
        end
    end

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        cmd_n       = cmd_q;
        valid_n     = 1'b0;
        is_write_n  = is_write;
        wcnt_n      = write_cnt;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !bus.lcd_busy) begin
                    pop        = 1'b1;
                    cmd_n      = fifo_head;
                    valid_n    = 1'b1;
                    timer_n    = '0;
                    is_write_n = (fifo_head == CMD_WRITE);
                    state_n    = ST_ACK;
                end
            end
            ST_ACK, ST_WDONE, ST_RUN: begin
                // Watchdog wins over any normal progress; the command is dropped.
                if (timer == TW'(TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    timer_n     = '0;
                    state_n     = ST_IDLE;
                end else begin
                    timer_n = timer + TW'(1);
                    if (state == ST_ACK) begin
                        if (bus.lcd_busy) begin
                            state_n = is_write ? ST_WDONE : ST_RUN;
                        end
                    end else if (state == ST_WDONE) begin
                        if (bus.lcd_done) begin
                            wcnt_n  = write_cnt + CNT_W'(1);
                            state_n = ST_RUN;
                        end
                    end else begin
                        if (!bus.lcd_busy) begin
                            state_n = ST_IDLE;
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            cmd_q       <= '0;
            valid_q     <= 1'b0;
            is_write    <= 1'b0;
            write_cnt   <= '0;
            err_timeout <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            cmd_q       <= cmd_n;
            valid_q     <= valid_n;
            is_write    <= is_write_n;
            write_cnt   <= wcnt_n;
            // A new error in the clearing cycle keeps the flag set.
            err_timeout <= (err_timeout && !clr_err) || timeout_hit;
            err_illegal <= (err_illegal && !clr_err) || new_illegal;
        end
    end

    assign bus.lcd_cmd       = cmd_q;
    assign bus.lcd_cmd_valid = valid_q;
    assign idle              = fifo_empty && (state == ST_IDLE) && !bus.lcd_busy;

endmodule
